cpu_req_driver: RTL and testbench

- Processor-side initiator for one L1 cache CPU port. It replaces the hand-written rden/wren stimulus in the standalone benches.
- Executes a small loadable program of READ/WRITE/DELAY/HALT operations against the cache's interface_ready / rden / wren / data_out_valid handshake.
- Honours pause_processors, checks read data against expected values, and reports progress and errors.
- One instance per L1 (a and b) in the L1 complex bench.

---
 rtl/cpu_drv_pkg.sv | 56 +++++
 rtl/cpu_drv_prog_mem.sv | 36 +++
 rtl/cpu_req_driver.sv | 256 +++++++++++++++++++++++++
 tb/tb_cpu_req_driver.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_drv_pkg.sv
// cpu_drv_pkg
// Shared definitions for the CPU request driver: opcode values, FSM state
// encoding, prog_word field offsets, the decoded program-entry struct and
// small helper functions used by cpu_req_driver.
package cpu_drv_pkg;

  // Width of one program word: {op[66:65], expect_en[64], addr[63:32], data[31:0]}
  localparam int PROG_W   = 67;
  localparam int OP_MSB   = 66;
  localparam int OP_LSB   = 65;
  localparam int EXP_BIT  = 64;
  localparam int ADDR_MSB = 63;
  localparam int ADDR_LSB = 32;
  localparam int DATA_MSB = 31;
  localparam int DATA_LSB = 0;

  // Opcodes
  localparam logic [1:0] OP_DELAY = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_ISSUE   = 3'd2;
  localparam logic [2:0] ST_WAIT_RD = 3'd3;
  localparam logic [2:0] ST_WAIT_WR = 3'd4;
  localparam logic [2:0] ST_DELAY   = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;
  localparam logic [2:0] ST_ERROR   = 3'd7;

  typedef struct packed {
    logic [1:0]  op;
    logic        exp_en;
    logic [31:0] addr;
    logic [31:0] data;
  } prog_entry_t;

  // Split a raw program word into its fields
  function automatic prog_entry_t decode_word(input logic [PROG_W-1:0] w);
    prog_entry_t e;
    e.op     = w[OP_MSB:OP_LSB];
    e.exp_en = w[EXP_BIT];
    e.addr   = w[ADDR_MSB:ADDR_LSB];
    e.data   = w[DATA_MSB:DATA_LSB];
    return e;
  endfunction

  // Delay count preload: the DELAY state dwells (count+1) cycles, and a
  // requested length of 0 still takes one cycle.
  function automatic logic [7:0] delay_load(input logic [7:0] n);
    return (n == 8'd0) ? 8'd0 : (n - 8'd1);
  endfunction

endpackage

// File: rtl/cpu_drv_prog_mem.sv
// cpu_drv_prog_mem
// Program store for cpu_req_driver: DEPTH x 67-bit register file with a
// synchronous write port and an asynchronous read port. Not reset.
// Ports:
//   clk   - clock
//   we    - write enable (already gated by the driver's busy flag)
//   waddr - write address
//   wdata - write word
//   raddr - read address
//   rdata - read word (combinational)
module cpu_drv_prog_mem
  import cpu_drv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [PROG_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [PROG_W-1:0] rdata
);

  logic [PROG_W-1:0] mem_r [DEPTH];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/cpu_req_driver.sv
// cpu_req_driver
// Processor-side initiator for one L1 CPU port. Runs a loaded program of
// READ / WRITE / DELAY / HALT entries against the cache handshake, checks
// read data against expected values and reports progress and errors.
// Ports:
//   clk, reset        - clock, synchronous active-low reset
//   prog_wren/addr/word - program load port (ignored while busy)
//   start             - begin execution at entry 0
//   interface_ready, pause, rd_data, rd_data_valid - cache / arbiter side
//   addr_out, wr_data, rden, wren - request to the cache
//   busy, done, pc    - progress
//   last_rd_data, mismatch_cnt, timeout_err, protocol_err - results/errors
module cpu_req_driver
  import cpu_drv_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          prog_wren,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [66:0]                   prog_word,
  input  logic                          start,
  input  logic                          interface_ready,
  input  logic                          pause,
  input  logic [31:0]                   rd_data,
  input  logic                          rd_data_valid,
  output logic [31:0]                   addr_out,
  output logic [31:0]                   wr_data,
  output logic                          rden,
  output logic                          wren,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(PROG_DEPTH)-1:0] pc,
  output logic [31:0]                   last_rd_data,
  output logic [CNT_W-1:0]              mismatch_cnt,
  output logic                          timeout_err,
  output logic                          protocol_err
);

  localparam int                AW       = $clog2(PROG_DEPTH);
  localparam int                TW       = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0]     PC_LAST  = AW'(PROG_DEPTH - 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [2:0]        state_r;
  logic [AW-1:0]     pc_r;
  logic [1:0]        op_r;
  logic              exp_r;
  logic [31:0]       addr_r;
  logic [31:0]       data_r;
  logic [31:0]       last_rd_r;
  logic [CNT_W-1:0]  mis_cnt_r;
  logic              tmo_err_r;
  logic              prot_err_r;
  logic              busy_r;
  logic              done_r;
  logic [TW-1:0]     tmo_cnt_r;
  logic [7:0]        dly_cnt_r;

  logic [PROG_W-1:0] mem_word_s;
  prog_entry_t       entry_s;
  logic              pc_last_s;
  logic              mem_we_s;

  // Program loads are only honoured while the program is not running
  assign mem_we_s = prog_wren & ~busy_r;

  cpu_drv_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (prog_addr),
    .wdata (prog_word),
    .raddr (pc_r),
    .rdata (mem_word_s)
  );

  assign entry_s   = decode_word(mem_word_s);
  assign pc_last_s = (pc_r == PC_LAST);

  // Request strobes: combinational from ISSUE, gated by readiness and pause
  always_comb begin
    rden = 1'b0;
    wren = 1'b0;
    if ((state_r == ST_ISSUE) && interface_ready && !pause) begin
      if (op_r == OP_READ) begin
        rden = 1'b1;
      end else if (op_r == OP_WRITE) begin
        wren = 1'b1;
      end else begin
        rden = 1'b0;
        wren = 1'b0;
      end
    end else begin
      rden = 1'b0;
      wren = 1'b0;
    end
  end

  // Main sequencer: FSM, pc, counters, compare and sticky error flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      pc_r       <= '0;
      op_r       <= 2'b00;
      exp_r      <= 1'b0;
      addr_r     <= 32'd0;
      data_r     <= 32'd0;
      last_rd_r  <= 32'd0;
      mis_cnt_r  <= '0;
      tmo_err_r  <= 1'b0;
      prot_err_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      tmo_cnt_r  <= '0;
      dly_cnt_r  <= 8'd0;
    end else begin
      // Read data outside a read wait (including on the acceptance edge,
      // when the state is still ISSUE) is a protocol violation.
      if (rd_data_valid && (state_r != ST_WAIT_RD)) begin
        prot_err_r <= 1'b1;
      end

      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_r    <= ST_FETCH;
            pc_r       <= '0;
            mis_cnt_r  <= '0;
            tmo_err_r  <= 1'b0;
            prot_err_r <= 1'b0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
          end
        end

        ST_FETCH: begin
          addr_r <= entry_s.addr;
          data_r <= entry_s.data;
          op_r   <= entry_s.op;
          exp_r  <= entry_s.exp_en;
          case (entry_s.op)
            OP_DELAY: begin
              dly_cnt_r <= delay_load(entry_s.data[7:0]);
              state_r   <= ST_DELAY;
            end
            OP_READ, OP_WRITE: begin
              state_r <= ST_ISSUE;
            end
            OP_HALT: begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
            default: begin
              state_r <= ST_IDLE;
            end
          endcase
        end

        ST_ISSUE: begin
          if (rden) begin
            state_r   <= ST_WAIT_RD;
            tmo_cnt_r <= '0;
          end else if (wren) begin
            state_r   <= ST_WAIT_WR;
            tmo_cnt_r <= '0;
          end
        end

        ST_WAIT_RD: begin
          // pause does not hold off returning data
          if (rd_data_valid) begin
            last_rd_r <= rd_data;
            if (exp_r && (rd_data != data_r) && (mis_cnt_r != CNT_MAX)) begin
              mis_cnt_r <= mis_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (pc_last_s) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              pc_r    <= pc_r + AW'(1);
              state_r <= ST_FETCH;
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            tmo_err_r <= 1'b1;
            state_r   <= ST_ERROR;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end

        ST_WAIT_WR: begin
          // Write completes once the cache is ready again and not paused
          if (interface_ready && !pause) begin
            if (pc_last_s) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              pc_r    <= pc_r + AW'(1);
              state_r <= ST_FETCH;
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            tmo_err_r <= 1'b1;
            state_r   <= ST_ERROR;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end
        end

        ST_DELAY: begin
          // Wall-clock delay: pause is deliberately ignored
          if (dly_cnt_r == 8'd0) begin
            if (pc_last_s) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              pc_r    <= pc_r + AW'(1);
              state_r <= ST_FETCH;
            end
          end else begin
            dly_cnt_r <= dly_cnt_r - 8'd1;
          end
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign addr_out     = addr_r;
  assign wr_data      = data_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign pc           = pc_r;
  assign last_rd_data = last_rd_r;
  assign mismatch_cnt = mis_cnt_r;
  assign timeout_err  = tmo_err_r;
  assign protocol_err = prot_err_r;

endmodule

// File: tb/tb_cpu_req_driver.sv
// tb_cpu_req_driver
// Directed self-checking bench for cpu_req_driver with a small cache model
// (write echo memory, 3-cycle read latency, optional data override/drop).
module tb_cpu_req_driver;

  localparam logic [1:0] T_DELAY = 2'b00;
  localparam logic [1:0] T_READ  = 2'b01;
  localparam logic [1:0] T_WRITE = 2'b10;
  localparam logic [1:0] T_HALT  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_wren;
  logic [3:0]  prog_addr;
  logic [66:0] prog_word;
  logic        start;
  logic        interface_ready;
  logic        pause;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic [31:0] addr_out;
  logic [31:0] wr_data;
  logic        rden;
  logic        wren;
  logic        busy;
  logic        done;
  logic [3:0]  pc;
  logic [31:0] last_rd_data;
  logic [7:0]  mismatch_cnt;
  logic        timeout_err;
  logic        protocol_err;

  int total = 0;
  int bad   = 0;

  // cache model controls
  logic        drop_rd;
  logic        ovr_en;
  logic [31:0] ovr_val;
  logic        inj_valid;
  logic [31:0] inj_data;

  logic [31:0] mem_model [256];
  logic [2:0]  pend;
  logic [31:0] pd0, pd1, pd2;
  int          wr_cnt;
  int          rd_cnt;

  always #5 clk = ~clk;

  cpu_req_driver #(.PROG_DEPTH(16), .TIMEOUT(64), .CNT_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .prog_wren       (prog_wren),
    .prog_addr       (prog_addr),
    .prog_word       (prog_word),
    .start           (start),
    .interface_ready (interface_ready),
    .pause           (pause),
    .rd_data         (rd_data),
    .rd_data_valid   (rd_data_valid),
    .addr_out        (addr_out),
    .wr_data         (wr_data),
    .rden            (rden),
    .wren            (wren),
    .busy            (busy),
    .done            (done),
    .pc              (pc),
    .last_rd_data    (last_rd_data),
    .mismatch_cnt    (mismatch_cnt),
    .timeout_err     (timeout_err),
    .protocol_err    (protocol_err)
  );

  // cache model: echo memory with 3-cycle read latency, request counters
  always @(posedge clk) begin
    if (!reset) begin
      pend <= 3'b000;
    end else begin
      pend <= {pend[1:0], rden & ~drop_rd};
    end
    pd0 <= ovr_en ? ovr_val : mem_model[addr_out[9:2]];
    pd1 <= pd0;
    pd2 <= pd1;
    if (wren) mem_model[addr_out[9:2]] <= wr_data;
  end

  always @(posedge clk) begin
    if (wren) wr_cnt <= wr_cnt + 1;
    if (rden) rd_cnt <= rd_cnt + 1;
  end

  initial begin
    wr_cnt = 0;
    rd_cnt = 0;
  end

  assign rd_data_valid = pend[2] | inj_valid;
  assign rd_data       = inj_valid ? inj_data : pd2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [3:0] a, input logic [1:0] op, input logic e,
                      input logic [31:0] ad, input logic [31:0] d);
    prog_wren = 1'b1;
    prog_addr = a;
    prog_word = {op, e, ad, d};
    @(negedge clk);
    prog_wren = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  int w0, r0, n;

  initial begin
    reset = 1'b0; prog_wren = 1'b0; prog_addr = 4'd0; prog_word = 67'd0;
    start = 1'b0; interface_ready = 1'b1; pause = 1'b0;
    drop_rd = 1'b0; ovr_en = 1'b0; ovr_val = 32'd0;
    inj_valid = 1'b0; inj_data = 32'd0;
    step(3);
    check("rst_flags", 32'({busy, done, rden, wren, timeout_err, protocol_err}), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_last", last_rd_data, 32'd0);
    reset = 1'b1;
    step(1);

    // 1: write then read-back, then HALT
    load(4'd0, T_WRITE, 1'b0, 32'h100, 32'hDEADBEEF);
    load(4'd1, T_READ,  1'b1, 32'h100, 32'hDEADBEEF);
    load(4'd2, T_HALT,  1'b0, 32'h0,   32'h0);
    w0 = wr_cnt; r0 = rd_cnt;
    go();
    check("t1_busy", 32'(busy), 32'd1);
    wait_done("t1_done", 200);
    check("t1_wren_cnt", 32'(wr_cnt - w0), 32'd1);
    check("t1_rden_cnt", 32'(rd_cnt - r0), 32'd1);
    check("t1_last", last_rd_data, 32'hDEADBEEF);
    check("t1_mis", 32'(mismatch_cnt), 32'd0);
    check("t1_pc", 32'(pc), 32'd2);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_errs", 32'({timeout_err, protocol_err}), 32'd0);

    // 2: read mismatch, execution continues
    load(4'd0, T_READ,  1'b1, 32'h200, 32'h12345678);
    load(4'd1, T_WRITE, 1'b0, 32'h300, 32'h00000055);
    load(4'd2, T_HALT,  1'b0, 32'h0,   32'h0);
    ovr_en = 1'b1; ovr_val = 32'hBAADBEEF;
    w0 = wr_cnt;
    go();
    wait_done("t2_done", 200);
    ovr_en = 1'b0;
    check("t2_mis", 32'(mismatch_cnt), 32'd1);
    check("t2_last", last_rd_data, 32'hBAADBEEF);
    check("t2_next_wr", 32'(wr_cnt - w0), 32'd1);
    check("t2_pc", 32'(pc), 32'd2);

    // 3: pause held in ISSUE for a write; load while busy is ignored
    load(4'd0, T_WRITE, 1'b0, 32'h104, 32'h11111111);
    load(4'd1, T_HALT,  1'b0, 32'h0,   32'h0);
    pause = 1'b1;
    w0 = wr_cnt;
    go();
    step(1);
    load(4'd1, T_WRITE, 1'b0, 32'h108, 32'h22222222);
    step(8);
    check("t3_wren_paused", 32'(wren), 32'd0);
    check("t3_no_wr", 32'(wr_cnt - w0), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    pause = 1'b0;
    #1;
    check("t3_wren_pulse", 32'(wren), 32'd1);
    step(1);
    check("t3_wren_low", 32'(wren), 32'd0);
    check("t3_one_wr", 32'(wr_cnt - w0), 32'd1);
    wait_done("t3_done", 100);
    check("t3_pc_halt", 32'(pc), 32'd1);
    check("t3_total_wr", 32'(wr_cnt - w0), 32'd1);

    // 4: read never answered -> timeout 64 cycles after acceptance
    load(4'd0, T_READ, 1'b0, 32'h100, 32'h0);
    load(4'd1, T_HALT, 1'b0, 32'h0,   32'h0);
    drop_rd = 1'b1;
    go();
    step(1);
    check("t4_rden", 32'(rden), 32'd1);
    step(64);
    check("t4_tmo_early", 32'(timeout_err), 32'd0);
    step(1);
    check("t4_tmo", 32'(timeout_err), 32'd1);
    check("t4_done_busy", 32'({done, busy}), 32'b10);
    drop_rd = 1'b0;
    go();
    check("t4_restart_clr", 32'({timeout_err, done, busy}), 32'b001);
    check("t4_restart_pc", 32'(pc), 32'd0);
    wait_done("t4_rerun_done", 200);
    check("t4_rerun_pc", 32'(pc), 32'd1);
    check("t4_rerun_tmo", 32'(timeout_err), 32'd0);
    check("t4_rerun_last", last_rd_data, 32'hDEADBEEF);

    // 5: stray read data during DELAY 5
    load(4'd0, T_DELAY, 1'b0, 32'h0, 32'd5);
    load(4'd1, T_HALT,  1'b0, 32'h0, 32'h0);
    go();
    step(1);
    inj_valid = 1'b1; inj_data = 32'hCAFEF00D;
    step(1);
    inj_valid = 1'b0;
    check("t5_prot", 32'(protocol_err), 32'd1);
    check("t5_last_kept", last_rd_data, 32'hDEADBEEF);
    check("t5_busy", 32'(busy), 32'd1);
    wait_done("t5_done", 50);
    check("t5_pc", 32'(pc), 32'd1);
    check("t5_prot_sticky", 32'(protocol_err), 32'd1);

    // 6: reset in the middle of a read wait, then rerun intact program
    load(4'd0, T_WRITE, 1'b0, 32'h108, 32'hA5A5A5A5);
    load(4'd1, T_READ,  1'b1, 32'h108, 32'hA5A5A5A5);
    load(4'd2, T_HALT,  1'b0, 32'h0,   32'h0);
    drop_rd = 1'b1;
    go();
    n = 0;
    while (!rden && n < 20) begin
      step(1);
      n++;
    end
    check("t6_rden_seen", 32'(rden), 32'd1);
    step(3);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check("t6_rst_flags", 32'({busy, done, rden, wren, timeout_err, protocol_err}), 32'd0);
    check("t6_rst_pc", 32'(pc), 32'd0);
    check("t6_rst_addr", addr_out, 32'd0);
    check("t6_rst_wdata", wr_data, 32'd0);
    check("t6_rst_last", last_rd_data, 32'd0);
    check("t6_rst_mis", 32'(mismatch_cnt), 32'd0);
    drop_rd = 1'b0;
    w0 = wr_cnt; r0 = rd_cnt;
    go();
    wait_done("t6_done", 200);
    check("t6_pc", 32'(pc), 32'd2);
    check("t6_last", last_rd_data, 32'hA5A5A5A5);
    check("t6_mis", 32'(mismatch_cnt), 32'd0);
    check("t6_reqs", 32'({wr_cnt - w0, rd_cnt - r0} == {32'd1, 32'd1}), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
